// File: rtl/tpu_pkg.sv
// Shared definitions for the tpumac result path.
// Holds the default result element width and array dimension, the element
// and row types, and a small width helper used by the deskew block.
package tpu_pkg;

    localparam int BITS_C = 16;
    localparam int DIM    = 8;

    typedef logic signed [BITS_C-1:0] c_elem_t;
    typedef c_elem_t c_row_t [DIM];

    // $clog2 that never returns 0, so a counter/pointer always has at least one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/deskew_lane.sv
// Enable-gated delay line for one result lane.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : shift when high, hold when low
//   din        : lane input
//   dout       : din delayed by DELAY enabled cycles (DELAY=0 is a plain wire)
module deskew_lane #(
    parameter int W     = 16,
    parameter int DELAY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DELAY == 0) begin : g_wire
            // The last lane arrives already aligned; control inputs are not needed.
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst_n ^ en;
            assign dout        = din;
        end else begin : g_sr
            logic [W-1:0] sr_reg [DELAY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DELAY; i++) begin
                        sr_reg[i] <= '0;
                    end
                end else if (en) begin
                    sr_reg[0] <= din;
                    for (int i = 1; i < DELAY; i++) begin
                        sr_reg[i] <= sr_reg[i-1];
                    end
                end
            end

            assign dout = sr_reg[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/mem_c_deskew.sv
// Output deskew buffer for the systolic array result stream.
// Lane j of a result row arrives j enabled cycles after lane 0. Each lane is
// delayed by DIM-1-j so a whole row lines up, aligned rows are queued in a
// DEPTH-row FIFO, and the head row is offered with a valid/ready handshake.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   en          : advance the deskew pipeline (FIFO output side always runs)
//   in_valid    : lane-0 element of a new row present (ignored when en=0)
//   Cin         : skewed lane inputs, Cin[j] belongs to the row started j en-cycles ago
//   out_ready   : consumer accepts the head row
//   out_valid   : head row available
//   Cout        : head row (holds the last popped row while empty)
//   Crow        : tile row index of the head row
//   done        : one-cycle pulse after row DIM-1 of a tile is popped
//   overflow    : sticky, an aligned row was dropped on a full FIFO
module mem_c_deskew #(
    parameter int BITS_C = tpu_pkg::BITS_C,
    parameter int DIM    = tpu_pkg::DIM,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic [DIM-1:0][BITS_C-1:0]    Cin,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DIM-1:0][BITS_C-1:0]    Cout,
    output logic [$clog2(DIM)-1:0]        Crow,
    output logic                          done,
    output logic                          overflow
);

    import tpu_pkg::*;

    localparam int PTR_W  = clog2_min1(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int CROW_W = $clog2(DIM);

    typedef logic [DIM-1:0][BITS_C-1:0] row_t;

    // ---------------- deskew ----------------
    row_t aligned;
    logic tracker_out;
    logic row_valid;

    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
            deskew_lane #(
                .W     (BITS_C),
                .DELAY (DIM - 1 - gi)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .din   (Cin[gi]),
                .dout  (aligned[gi])
            );
        end
    endgenerate

    // in_valid travels alongside lane 0 so it marks the cycle the row is complete.
    deskew_lane #(
        .W     (1),
        .DELAY (DIM - 1)
    ) u_vtrack (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (in_valid),
        .dout  (tracker_out)
    );

    assign row_valid = tracker_out & en;

    // ---------------- row FIFO ----------------
    row_t             mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CROW_W-1:0] crow_reg;
    logic             done_reg;
    logic             overflow_reg;
    logic             pop;
    logic             push;

    assign pop  = (count_reg != '0) & out_ready;
    // A full FIFO still takes the new row when the head leaves in the same cycle.
    assign push = row_valid & ((count_reg != CNT_W'(DEPTH)) | pop);

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            crow_reg     <= '0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= aligned;
                wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                crow_reg   <= (crow_reg == CROW_W'(DIM - 1)) ? '0 : crow_reg + CROW_W'(1);
            end
            count_reg <= count_next;
            done_reg  <= pop && (crow_reg == CROW_W'(DIM - 1));
            if (row_valid && !push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // While empty, the slot just behind the read pointer still holds the last
    // popped row (writes only land at rd_ptr when empty), so Cout keeps showing it.
    assign out_valid = (count_reg != '0);
    assign Cout      = out_valid ? mem_reg[rd_ptr_reg] : mem_reg[rd_ptr_reg - PTR_W'(1)];
    assign Crow      = crow_reg;
    assign done      = done_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_mem_c_deskew.sv
module tb_mem_c_deskew;

    localparam int BITS_C = 16;
    localparam int DIM    = 8;
    localparam int DEPTH  = 4;

    typedef logic [DIM-1:0][BITS_C-1:0] row_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    row_t       Cin = '0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    row_t       Cout;
    logic [2:0] Crow;
    logic       done;
    logic       overflow;

    mem_c_deskew #(
        .BITS_C (BITS_C),
        .DIM    (DIM),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .Cin       (Cin),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .Cout      (Cout),
        .Crow      (Crow),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: logical rows by start index, a row queue, and head bookkeeping.
    row_t hist [int];
    row_t mq [$];
    row_t m_last;
    int   m_crow;
    bit   m_done;
    bit   m_ovf;
    int   ecnt;

    function automatic row_t pattern(input logic [15:0] base);
        row_t r;
        for (int j = 0; j < DIM; j++) r[j] = base + 16'(j);
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int j = 0; j < DIM; j++) r[j] = 16'($urandom);
        return r;
    endfunction

    function automatic row_t exp_cout();
        return (mq.size() != 0) ? mq[0] : m_last;
    endfunction

    task automatic model_clear();
        hist.delete();
        mq.delete();
        m_last = '0;
        m_crow = 0;
        m_done = 0;
        m_ovf  = 0;
        ecnt   = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: called at a negedge, drives inputs, returns at the next negedge
    // with the model advanced to match.
    task automatic tick(input bit e, input bit v, input row_t r, input bit rdy);
        row_t cin;
        bit   pop, comp, push;
        row_t done_row;
        if (e && v) hist[ecnt] = r;
        for (int j = 0; j < DIM; j++) begin
            if (e && hist.exists(ecnt - j)) cin[j] = hist[ecnt - j][j];
            else cin[j] = 16'($urandom);
        end
        en        = e;
        in_valid  = e ? v : 1'($urandom);
        Cin       = cin;
        out_ready = rdy;
        pop  = (mq.size() != 0) && rdy;
        comp = e && hist.exists(ecnt - (DIM - 1));
        push = comp && ((mq.size() < DEPTH) || pop);
        done_row = comp ? hist[ecnt - (DIM - 1)] : '0;
        @(posedge clk);
        m_done = 0;
        if (pop) begin
            m_last = mq.pop_front();
            m_done = (m_crow == DIM - 1);
            m_crow = (m_crow + 1) % DIM;
        end
        if (push) mq.push_back(done_row);
        if (comp && !push) m_ovf = 1;
        if (e) ecnt++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (Cout !== '0) begin bad++; $display("FAIL reset_cout got=%h want=0", Cout); end
        total++; if (Crow !== 3'd0) begin bad++; $display("FAIL reset_crow got=%0d want=0", Crow); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        do_reset();
        for (int k = 0; k < 10; k++) tick(1, (k == 0) || (k == 5), rand_row(), 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b want=1", out_valid); end
        // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", out_valid); end
        total++; if (Cout !== '0) begin bad++; $display("FAIL async_cout got=%h want=0", Cout); end
        total++; if (Crow !== 3'd0) begin bad++; $display("FAIL async_crow got=%0d want=0", Crow); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL async_done got=%b want=0", done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL async_ovf got=%b want=0", overflow); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        // The partial row that was in the skew pipeline must not reappear.
        for (int k = 0; k < 10; k++) begin
            tick(1, 0, '0, 0);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_empty cyc=%0d got=%b want=0", k, out_valid); end
        end
        $display("test_reset: checks so far total=%0d", total);
    endtask

    task automatic test_single_row();
        do_reset();
        tick(1, 1, pattern(16'd100), 1);
        for (int k = 0; k < 12; k++) begin
            // After tick k the bench sits in cycle t+k+1; the row is due at t+8.
            total++; if (out_valid !== (k == 7)) begin bad++; $display("FAIL single_valid cyc=t+%0d got=%b want=%b", k + 1, out_valid, (k == 7)); end
            if (k == 7) begin
                total++; if (Cout !== pattern(16'd100)) begin bad++; $display("FAIL single_cout got=%h want=%h", Cout, pattern(16'd100)); end
                total++; if (Crow !== 3'd0) begin bad++; $display("FAIL single_crow got=%0d want=0", Crow); end
            end
            tick(1, 0, '0, 1);
        end
        $display("test_single_row: checks so far total=%0d", total);
    endtask

    task automatic test_full_tile();
        int vidx = 0;
        int dcnt = 0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (out_valid === 1'b1) begin
                total++; if (Cout !== pattern(16'(vidx * 16)) || Crow !== 3'(vidx)) begin bad++; $display("FAIL tile_row idx=%0d got=%h/%0d want=%h/%0d", vidx, Cout, Crow, pattern(16'(vidx * 16)), vidx); end
                vidx++;
            end
            tick(1, k < 8, pattern(16'(k * 16)), 1);
            if (done === 1'b1) dcnt++;
            total++; if (out_valid !== (mq.size() != 0)) begin bad++; $display("FAIL tile_valid got=%b want=%b", out_valid, (mq.size() != 0)); end
            total++; if (done !== m_done) begin bad++; $display("FAIL tile_done got=%b want=%b", done, m_done); end
        end
        total++; if (vidx != 8) begin bad++; $display("FAIL tile_rows got=%0d want=8", vidx); end
        total++; if (dcnt != 1) begin bad++; $display("FAIL tile_done_count got=%0d want=1", dcnt); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL tile_ovf got=%b want=0", overflow); end
        $display("test_full_tile: checks so far total=%0d", total);
    endtask

    task automatic test_backpressure();
        int got = 0;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            tick(1, k < 5, pattern(16'(16'h0200 + k * 16)), 0);
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL bp_ovf_track got=%b want=%b", overflow, m_ovf); end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow got=%b want=1", overflow); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", out_valid); end
        for (int k = 0; k < 8; k++) begin
            if (out_valid === 1'b1) begin
                total++; if (Cout !== pattern(16'(16'h0200 + got * 16))) begin bad++; $display("FAIL bp_row idx=%0d got=%h want=%h", got, Cout, pattern(16'(16'h0200 + got * 16))); end
                got++;
            end
            tick(1, 0, '0, 1);
            total++; if (Cout !== exp_cout()) begin bad++; $display("FAIL bp_cout got=%h want=%h", Cout, exp_cout()); end
        end
        total++; if (got != 4) begin bad++; $display("FAIL bp_row_count got=%0d want=4", got); end
        total++; if (Crow !== 3'd4) begin bad++; $display("FAIL bp_crow got=%0d want=4", Crow); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf_sticky got=%b want=1", overflow); end
        $display("test_backpressure: checks so far total=%0d", total);
    endtask

    task automatic test_full_pop();
        int got = 0;
        do_reset();
        // Rows 0..3 land at ticks 7..10; row 4 arrives at tick 11 while the FIFO is full.
        for (int k = 0; k < 12; k++) begin
            if (k == 11) begin
                total++; if (out_valid !== 1'b1 || mq.size() != DEPTH) begin bad++; $display("FAIL fp_full got_valid=%b model_rows=%0d want=1/%0d", out_valid, mq.size(), DEPTH); end
            end
            tick(1, k < 5, pattern(16'(16'h0F00 + k * 16)), k == 11);
        end
        for (int k = 0; k < 3; k++) tick(1, 0, '0, 0);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fp_overflow got=%b want=0", overflow); end
        for (int k = 0; k < 8; k++) begin
            if (out_valid === 1'b1) begin
                total++; if (Cout !== pattern(16'(16'h0F10 + got * 16))) begin bad++; $display("FAIL fp_row idx=%0d got=%h want=%h", got, Cout, pattern(16'(16'h0F10 + got * 16))); end
                got++;
            end
            tick(1, 0, '0, 1);
        end
        total++; if (got != 4) begin bad++; $display("FAIL fp_remaining got=%0d want=4", got); end
        total++; if (Crow !== 3'd5) begin bad++; $display("FAIL fp_crow got=%0d want=5", Crow); end
        $display("test_full_pop: checks so far total=%0d", total);
    endtask

    task automatic test_en_stall();
        row_t ra, rb;
        ra = pattern(16'h8000);
        rb = pattern(16'hFFFC);
        do_reset();
        for (int k = 0; k < 16; k++) begin
            bit e;
            e = !(k >= 3 && k <= 5);
            tick(e, (k == 0) || (k == 1), (k == 0) ? ra : rb, 1);
            // Three stalled cycles push the rows from t+8/t+9 to t+11/t+12.
            total++; if (out_valid !== (k == 10 || k == 11)) begin bad++; $display("FAIL stall_valid cyc=t+%0d got=%b want=%b", k + 1, out_valid, (k == 10 || k == 11)); end
            if (k == 10) begin
                total++; if (Cout !== ra) begin bad++; $display("FAIL stall_row_a got=%h want=%h", Cout, ra); end
            end
            if (k == 11) begin
                total++; if (Cout !== rb) begin bad++; $display("FAIL stall_row_b got=%h want=%h", Cout, rb); end
            end
        end
        $display("test_en_stall: checks so far total=%0d", total);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            tick($urandom_range(0, 9) < 8, 1'($urandom), rand_row(), 1'($urandom));
            total++; if (out_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", k, out_valid, (mq.size() != 0)); end
            total++; if (Cout !== exp_cout()) begin bad++; $display("FAIL rnd_cout cyc=%0d got=%h want=%h", k, Cout, exp_cout()); end
            total++; if (Crow !== 3'(m_crow)) begin bad++; $display("FAIL rnd_crow cyc=%0d got=%0d want=%0d", k, Crow, m_crow); end
            total++; if (done !== m_done) begin bad++; $display("FAIL rnd_done cyc=%0d got=%b want=%b", k, done, m_done); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%b want=%b", k, overflow, m_ovf); end
        end
        $display("test_random: checks so far total=%0d", total);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_row();
        test_full_tile();
        test_backpressure();
        test_full_pop();
        test_en_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
